// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder.
// Contents: padder FSM state enum, 0x80 marker word, block geometry and
// the word indices that carry the 64-bit length field.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_DATA,
        ST_MARK,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO
    } pad_state_e;

    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    localparam int WORDS_PER_BLK = 16;
    localparam int IDX_W = $clog2(WORDS_PER_BLK);

    localparam logic [IDX_W-1:0] LEN_HI_IDX = IDX_W'(14);
    localparam logic [IDX_W-1:0] LEN_LO_IDX = IDX_W'(15);

endpackage

// File: rtl/sha256_pad_mask.sv
// sha256_pad_mask: masks the unused bytes of a message's last word and drops
// the 0x80 marker into the first free byte position.
// Ports:
//   data   in  32  last message word, first byte in [31:24]
//   nbytes in  3   valid bytes in data (0..4); 4 or more passes data through
//   word   out 32  masked word with marker inserted
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] word
);

    always_comb begin
        word = nbytes == 3'd0 ? PAD_MARKER :
               nbytes == 3'd1 ? {data[31:24], 24'h80_0000} :
               nbytes == 3'd2 ? {data[31:16], 16'h8000} :
               nbytes == 3'd3 ? {data[31:8], 8'h80} : data;
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streaming FIPS 180-4 padder turning a byte-counted
// 32-bit word stream into 512-bit blocks (marker, zero fill, bit length).
// Optional feature macro: SHA256_PAD_BLKCNT_EN adds the blk_count output.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     message word stream (first byte in [31:24])
//   in_last/in_nbytes             final word marker and its valid byte count
//   out_data/out_valid/out_ready  padded word stream to the hash core
//   out_first/out_blk_last        word 0 / word 15 of a block
//   out_msg_last                  word 15 of the final block of a message
//   blk_count                     blocks emitted since reset (macro only)
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 32
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    parameter int BLK_CNT_W = 16
`endif
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_blk_last,
    output logic        out_msg_last
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [BLK_CNT_W-1:0] blk_count
`endif
);

    pad_state_e       state_q, state_d, pad_next;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      out_data_q, out_data_d, masked, word;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             out_blk_last_q, out_blk_last_d;
    logic             out_msg_last_q, out_msg_last_d;
    logic             advance, in_fire, load;
    logic [63:0]      len;

    sha256_pad_mask u_mask (
        .data   (in_data),
        .nbytes (in_nbytes),
        .word   (masked)
    );

    // The output register may be refilled when empty or being drained.
    // in_ready is forced low while reset is asserted.
    always_comb begin
        advance  = !out_valid_q || out_ready;
        in_ready = rst && state_q == ST_DATA && advance;
        in_fire  = in_ready && in_valid;
        load     = in_fire || (state_q != ST_DATA && advance);
        idx_nx   = idx_q + IDX_W'(1);
        // After a marker or zero word, go to the length once the next slot is 14.
        pad_next = idx_nx == LEN_HI_IDX ? ST_LEN_HI : ST_ZERO;
        len      = 64'(cnt_q) << 3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_DATA;
        else      state_q <= state_d;
    end

    // A last word with 0..3 bytes already carries the marker, so it skips MARK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DATA:   if (in_fire && in_last) state_d = in_nbytes >= 3'd4 ? ST_MARK : pad_next;
            ST_MARK,
            ST_ZERO:   if (advance) state_d = pad_next;
            ST_LEN_HI: if (advance) state_d = ST_LEN_LO;
            ST_LEN_LO: if (advance) state_d = ST_DATA;
            default:   state_d = ST_DATA;
        endcase
    end

    always_comb begin
        word = state_q == ST_DATA   ? (in_last ? masked : in_data) :
               state_q == ST_MARK   ? PAD_MARKER :
               state_q == ST_LEN_HI ? len[63:32] :
               state_q == ST_LEN_LO ? len[31:0] : 32'h0;
        out_data_d     = load ? word : out_data_q;
        out_valid_d    = advance ? load : out_valid_q;
        out_first_d    = load ? idx_q == '0 : out_first_q;
        out_blk_last_d = load ? idx_q == LEN_LO_IDX : out_blk_last_q;
        out_msg_last_d = load ? state_q == ST_LEN_LO : out_msg_last_q;
        idx_d          = load ? idx_nx : idx_q;
        cnt_d          = in_fire ? cnt_q + (in_last ? CNT_W'(in_nbytes) : CNT_W'(4)) :
                         load && state_q == ST_LEN_LO ? '0 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_first_q    <= 1'b0;
            out_blk_last_q <= 1'b0;
            out_msg_last_q <= 1'b0;
            idx_q          <= '0;
            cnt_q          <= '0;
        end else begin
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_first_q    <= out_first_d;
            out_blk_last_q <= out_blk_last_d;
            out_msg_last_q <= out_msg_last_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_first    = out_first_q;
    assign out_blk_last = out_blk_last_q;
    assign out_msg_last = out_msg_last_q;

`ifdef SHA256_PAD_BLKCNT_EN
    logic [BLK_CNT_W-1:0] blk_count_q, blk_count_d;

    always_comb begin
        blk_count_d = out_valid_q && out_ready && out_blk_last_q ? blk_count_q + BLK_CNT_W'(1) : blk_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blk_count_q <= '0;
        else      blk_count_q <= blk_count_d;
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed self-checking bench for sha256_msg_padder.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_blk_last;
    logic        out_msg_last;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_count;
    logic [15:0] bc0;
`endif

    sha256_msg_padder dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_nbytes    (in_nbytes),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_first    (out_first),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last)
`ifdef SHA256_PAD_BLKCNT_EN
        ,
        .blk_count    (blk_count)
`endif
    );

    always #5 clk = ~clk;

    logic [34:0] cap[$];
    int          tcyc[$];
    int          cyc = 0;
    logic [31:0] ex[32];
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            cap.push_back({out_msg_last, out_blk_last, out_first, out_data});
            tcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int   t = 0;
        logic ok = 1'b0;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        in_valid  = 1'b1;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_words(input string tag, input int n);
        int t = 0;
        while (cap.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_count"}, 64'(cap.size()), 64'(n));
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) ex[i] = 32'h0;
        cap.delete();
        tcyc.delete();
    endtask

    task automatic cmp_stream(input string tag, input int n, input int msg_words);
        for (int i = 0; i < n; i++) begin
            logic [34:0] e, o;
            e = {(i % msg_words) == msg_words - 1, (i % 16) == 15, (i % 16) == 0, ex[i]};
            o = i < cap.size() ? cap[i] : 'x;
            check($sformatf("%s_w%0d", tag, i), 64'(o), 64'(e));
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = 3'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_first, out_blk_last, out_msg_last}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef SHA256_PAD_BLKCNT_EN
        check("rst_blk_count", 64'(blk_count), 64'd0);
`endif
        rst = 1'b1;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // "abc": single word, 3 bytes, one-cycle output latency
        clear_exp();
        ex[0]  = 32'h6162_6380;
        ex[15] = 32'h0000_0018;
        send(32'h6162_6300, 1'b1, 3'd3);
        check("abc_latency", 64'({out_valid, out_first, out_data}), {31'd0, 1'b1, 1'b1, 32'h6162_6380});
        wait_words("abc", 16);
        cmp_stream("abc", 16, 16);
        check("abc_no_bubble", 64'(tcyc[15] - tcyc[0]), 64'd15);

        // empty message immediately followed by "abc", back to back
        clear_exp();
        ex[0]  = 32'h8000_0000;
        ex[16] = 32'h6162_6380;
        ex[31] = 32'h0000_0018;
        send(32'h0, 1'b1, 3'd0);
        send(32'h6162_6300, 1'b1, 3'd3);
        wait_words("empty_abc", 32);
        cmp_stream("empty_abc", 32, 16);
        check("empty_abc_no_bubble", 64'(tcyc[31] - tcyc[0]), 64'd31);

        // "a": one byte
        clear_exp();
        ex[0]  = 32'h6180_0000;
        ex[15] = 32'h0000_0008;
        send(32'h6100_0000, 1'b1, 3'd1);
        wait_words("one_byte", 16);
        cmp_stream("one_byte", 16, 16);

        // "abcdef": full word then two bytes
        clear_exp();
        ex[0]  = 32'h6162_6364;
        ex[1]  = 32'h6566_8000;
        ex[15] = 32'h0000_0030;
        send(32'h6162_6364, 1'b0, 3'd4);
        send(32'h6566_7788, 1'b1, 3'd2);
        wait_words("six_bytes", 16);
        cmp_stream("six_bytes", 16, 16);

        // 55 bytes: marker lands in word 13, still one block
        clear_exp();
        for (int k = 0; k < 13; k++) ex[k] = 32'(32'h0101_0101 * (k + 1));
        ex[13] = 32'h0E0E_0E80;
        ex[15] = 32'h0000_01B8;
        for (int k = 0; k < 14; k++) send(32'(32'h0101_0101 * (k + 1)), k == 13, 3'd3);
        wait_words("b55", 16);
        repeat (4) @(posedge clk);
        #1;
        check("b55_one_block", 64'(cap.size()), 64'd16);
        check("b55_idle", 64'(out_valid), 64'd0);
        cmp_stream("b55", 16, 16);

        // 56 bytes: marker at word 14 spills into a second block
        clear_exp();
`ifdef SHA256_PAD_BLKCNT_EN
        bc0 = blk_count;
`endif
        for (int k = 0; k < 14; k++) ex[k] = 32'hC0DE_0000 + 32'(k);
        ex[14] = 32'h8000_0000;
        ex[31] = 32'h0000_01C0;
        for (int k = 0; k < 14; k++) send(32'hC0DE_0000 + 32'(k), k == 13, 3'd4);
        wait_words("b56", 32);
        cmp_stream("b56", 32, 32);
`ifdef SHA256_PAD_BLKCNT_EN
        check("b56_blk_count", 64'(16'(blk_count - bc0)), 64'd2);
`endif

        // backpressure: out_ready low for 5 cycles while word 7 is presented
        clear_exp();
        for (int k = 0; k < 10; k++) ex[k] = 32'hA500_0000 + 32'(k);
        ex[10] = 32'h8000_0000;
        ex[15] = 32'h0000_0140;
        fork
            begin
                for (int k = 0; k < 10; k++) send(32'hA500_0000 + 32'(k), k == 9, 3'd4);
            end
            begin
                int t;
                t = 0;
                while (cap.size() < 7 && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check($sformatf("bp_hold_c%0d", c),
                          64'({out_valid, in_ready, out_first, out_blk_last, out_data}),
                          {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA500_0007});
                    check($sformatf("bp_count_c%0d", c), 64'(cap.size()), 64'd7);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_words("bp", 16);
        cmp_stream("bp", 16, 16);

        // asynchronous reset in the middle of a message, then "abc"
        clear_exp();
        for (int k = 0; k < 5; k++) send(32'h5555_0000 + 32'(k), 1'b0, 3'd4);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
`ifdef SHA256_PAD_BLKCNT_EN
        check("midrst_blk_count", 64'(blk_count), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_exp();
        ex[0]  = 32'h6162_6380;
        ex[15] = 32'h0000_0018;
        send(32'h6162_6300, 1'b1, 3'd3);
        wait_words("post_rst_abc", 16);
        cmp_stream("post_rst_abc", 16, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
